// File: rtl/eth_rx_speed_detect.sv
// MII receive-clock rate detector: counts synchronized mii_rx_clk rises per 2^WINDOW_LOG2 reference cycles.
// Optional two-window hysteresis on the reported speed is enabled by defining ETH_RX_SPEED_DETECT_HYST_EN.
module eth_rx_speed_detect #(
  parameter int WINDOW_LOG2 = 12,
  parameter int LO10        = 70,
  parameter int HI10        = 95,
  parameter int LO100       = 770,
  parameter int HI100       = 870
) (
  input  logic                   rx_clk125,
  input  logic                   rst_n,
  input  logic                   mii_rx_clk,
  output logic [1:0]             speed,
  output logic                   link_clk_ok,
  output logic                   speed_change,
  output logic [WINDOW_LOG2:0]   edge_count
);

  localparam int CW = WINDOW_LOG2 + 1;
  localparam logic [CW-1:0] C_LO10  = CW'(LO10);
  localparam logic [CW-1:0] C_HI10  = CW'(HI10);
  localparam logic [CW-1:0] C_LO100 = CW'(LO100);
  localparam logic [CW-1:0] C_HI100 = CW'(HI100);

  typedef enum logic [1:0] {
    SPD_NONE = 2'b00,
    SPD_10   = 2'b01,
    SPD_100  = 2'b10,
    SPD_BAD  = 2'b11
  } speed_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
    logic [CW-1:0] res;
    res = v;
    if (inc && !(&v)) res = v + 1'b1;
    return res;
  endfunction

  function automatic speed_t classify(input logic [CW-1:0] t);
    speed_t res;
    if (t == '0)                          res = SPD_NONE;
    else if (t >= C_LO10 && t <= C_HI10)  res = SPD_10;
    else if (t >= C_LO100 && t <= C_HI100) res = SPD_100;
    else                                  res = SPD_BAD;
    return res;
  endfunction

  logic                   r_s1, r_s2, r_s3;
  logic [WINDOW_LOG2-1:0] r_cyc;
  logic [CW-1:0]          r_ecnt;
  logic [CW-1:0]          r_edge_count;
  speed_t                 r_speed;
  logic                   r_link_ok;
  logic                   r_chg;
`ifdef ETH_RX_SPEED_DETECT_HYST_EN
  speed_t                 r_cand;
`endif

  logic                   w_edge;
  logic                   w_win_end;
  logic [CW-1:0]          w_total;
  speed_t                 w_cls;
  logic                   w_load;
  speed_t                 w_speed_nxt;

  always_comb begin
    w_edge      = r_s2 & ~r_s3;
    w_win_end   = &r_cyc;
    // An edge detected on the window-end cycle still belongs to the ending window.
    w_total     = sat_inc(r_ecnt, w_edge);
    w_cls       = classify(w_total);
`ifdef ETH_RX_SPEED_DETECT_HYST_EN
    w_load      = w_win_end && (w_cls == r_cand);
`else
    w_load      = w_win_end;
`endif
    w_speed_nxt = r_speed;
    if (w_load) w_speed_nxt = w_cls;
  end

  always_ff @(posedge rx_clk125) begin
    if (!rst_n) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_cyc        <= '0;
      r_ecnt       <= '0;
      r_edge_count <= '0;
      r_speed      <= SPD_NONE;
      r_link_ok    <= 1'b0;
      r_chg        <= 1'b0;
`ifdef ETH_RX_SPEED_DETECT_HYST_EN
      r_cand       <= SPD_NONE;
`endif
    end else begin
      r_s1 <= mii_rx_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_cyc <= r_cyc + 1'b1;
      if (w_win_end) begin
        r_edge_count <= w_total;
        r_ecnt       <= '0;
      end else begin
        r_ecnt <= sat_inc(r_ecnt, w_edge);
      end
      r_speed   <= w_speed_nxt;
      r_link_ok <= (w_speed_nxt == SPD_10) || (w_speed_nxt == SPD_100);
      r_chg     <= (w_speed_nxt != r_speed);
`ifdef ETH_RX_SPEED_DETECT_HYST_EN
      if (w_win_end) r_cand <= w_cls;
`endif
    end
  end

  assign speed        = r_speed;
  assign link_clk_ok  = r_link_ok;
  assign speed_change = r_chg;
  assign edge_count   = r_edge_count;

endmodule
